// File: rtl/dp_pkg.sv
// Shared encodings for the pipelined register-file/ALU datapath.
// Imported by datapath_pipe and its iterative multiplier.
package dp_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_PASSA = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_XOR   = 3'd5,
        OP_MUL   = 3'd6,
        OP_RSVD  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        WS_ALU  = 2'd0,
        WS_DMEM = 2'd1,
        WS_CONS = 2'd2,
        WS_ABS  = 2'd3
    } wsel_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_MUL  = 2'd1,
        MS_DONE = 2'd2
    } mul_state_t;

    // Only arithmetic sources (ALU, abs) are allowed to move the status flags.
    function automatic logic writes_flags(input wsel_t ws);
        return (ws == WS_ALU) || (ws == WS_ABS);
    endfunction

endpackage

// File: rtl/dp_mul_iter.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, DW cycles.
// done is combinational in the last iteration so product can be captured on that edge.
module dp_mul_iter #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            done,
    output logic [2*DW-1:0] product
);

    localparam int CNTW = $clog2(DW);
    localparam logic [CNTW-1:0] LAST = CNTW'(DW - 1);

    logic            busy;
    logic [CNTW-1:0] cnt;
    logic [2*DW-1:0] mcand;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] partial;
    logic [DW-1:0]   mplier;

    // product already includes the current iteration's partial term
    always_comb begin
        partial = mplier[0] ? mcand : '0;
        product = acc + partial;
        done    = busy && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{DW{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage (execute/writeback) register-file datapath with WB forwarding,
// registered {V,C,N,Z} flags and a stalling iterative multiply.
module datapath_pipe
    import dp_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [1:0]    wsel,
    input  logic [AW-1:0] w_addr,
    input  logic          w_wr,
    input  logic [AW-1:0] rp_addr,
    input  logic          rp_rd,
    input  logic [AW-1:0] rq_addr,
    input  logic          rq_rd,
    input  logic [CW-1:0] w_cons,
    input  logic [2:0]    alu_op,
    input  logic [DW-1:0] dm_din,
    output logic [DW-1:0] rp_data,
    output logic          rp_zero,
    output logic [3:0]    flags,
    output logic          wb_valid
);

    logic [DW-1:0] rf [NREG];
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    flags_t        flags_q;

    alu_op_t    op;
    wsel_t      ws;
    mul_state_t state_q, state_d;

    logic            accept, is_mul, mul_start, mul_done;
    logic [2*DW-1:0] mul_prod;
    logic [AW-1:0]   mul_addr;
    logic            mul_wr;
    flags_t          mul_flags;

    logic [DW-1:0] rq_data, alu_y, abs_y, ex_y, cons_ext;
    logic [DW:0]   sum, dif;
    logic          alu_c, alu_v, abs_v;
    flags_t        ex_flags;

    assign op = alu_op_t'(alu_op);
    assign ws = wsel_t'(wsel);

    // Read ports: WB stage wins over the array so a dependent op can issue next cycle
    assign rp_data = !rp_rd ? '0 :
                     (wb_valid && wb_addr == rp_addr) ? wb_data : rf[rp_addr];
    assign rq_data = !rq_rd ? '0 :
                     (wb_valid && wb_addr == rq_addr) ? wb_data : rf[rq_addr];
    assign rp_zero = (rp_data == '0);

    assign issue_ready = (state_q != MS_MUL);
    assign accept      = issue_valid && issue_ready;
    assign is_mul      = (op == OP_MUL) && (ws == WS_ALU);
    assign mul_start   = accept && is_mul;

    always_comb begin
        sum   = {1'b0, rp_data} + {1'b0, rq_data};
        dif   = {1'b0, rp_data} - {1'b0, rq_data};
        alu_y = rp_data;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_y = sum[DW-1:0];
                alu_c = sum[DW];
                alu_v = (rp_data[DW-1] == rq_data[DW-1]) && (sum[DW-1] != rp_data[DW-1]);
            end
            OP_SUB: begin
                // bit DW of the widened difference is the unsigned borrow
                alu_y = dif[DW-1:0];
                alu_c = dif[DW];
                alu_v = (rp_data[DW-1] != rq_data[DW-1]) && (dif[DW-1] != rp_data[DW-1]);
            end
            OP_AND:  alu_y = rp_data & rq_data;
            OP_OR:   alu_y = rp_data | rq_data;
            OP_XOR:  alu_y = rp_data ^ rq_data;
            default: alu_y = rp_data;
        endcase
    end

    // abs of the most-negative value wraps to itself and raises V
    assign abs_y = rp_data[DW-1] ? (~rp_data + 1'b1) : rp_data;
    assign abs_v = (rp_data == {1'b1, {(DW-1){1'b0}}});

    always_comb begin
        cons_ext          = '0;
        cons_ext[CW-1:0]  = w_cons;
    end

    always_comb begin
        ex_y     = alu_y;
        ex_flags = '0;
        case (ws)
            WS_ALU: begin
                ex_y       = alu_y;
                ex_flags.v = alu_v;
                ex_flags.c = alu_c;
            end
            WS_DMEM: ex_y = dm_din;
            WS_CONS: ex_y = cons_ext;
            WS_ABS: begin
                ex_y       = abs_y;
                ex_flags.v = abs_v;
            end
            default: ex_y = alu_y;
        endcase
        ex_flags.n = ex_y[DW-1];
        ex_flags.z = (ex_y == '0);
    end

    always_comb begin
        mul_flags.v = 1'b0;
        mul_flags.c = |mul_prod[2*DW-1:DW];
        mul_flags.n = mul_prod[DW-1];
        mul_flags.z = (mul_prod[DW-1:0] == '0);
    end

    dp_mul_iter #(.DW(DW)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (rp_data),
        .b       (rq_data),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MS_IDLE;
        else     state_q <= state_d;
    end

    // DONE behaves like IDLE for issue, so a multiply can follow a multiply directly
    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE, MS_DONE: state_d = mul_start ? MS_MUL : MS_IDLE;
            MS_MUL:           if (mul_done) state_d = MS_DONE;
            default:          state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_addr <= '0;
            mul_wr   <= 1'b0;
        end else if (mul_start) begin
            mul_addr <= w_addr;
            mul_wr   <= w_wr;
        end
    end

    // mul_done and a fresh accept are exclusive: issue_ready is low while multiplying
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flags_q  <= '0;
        end else begin
            if (wb_valid) rf[wb_addr] <= wb_data;
            wb_valid <= 1'b0;
            if (mul_done) begin
                wb_valid <= mul_wr;
                wb_addr  <= mul_addr;
                wb_data  <= mul_prod[DW-1:0];
                if (mul_wr) flags_q <= mul_flags;
            end else if (accept && !is_mul) begin
                wb_valid <= w_wr;
                wb_addr  <= w_addr;
                wb_data  <= ex_y;
                if (w_wr && writes_flags(ws)) flags_q <= ex_flags;
            end
        end
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: reference model + flag scoreboard on WB,
// plus a narrow DW=8/NREG=4 instance for the parameter sweep.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, w_wr, rp_rd, rq_rd, rp_zero, wb_valid;
    logic [1:0]  wsel;
    logic [3:0]  w_addr, rp_addr, rq_addr, flags;
    logic [7:0]  w_cons;
    logic [2:0]  alu_op;
    logic [15:0] dm_din, rp_data;

    logic        s8_valid, s8_ready, s8_wr, s8_rp_rd, s8_rq_rd, s8_rp_zero, s8_wbv;
    logic [1:0]  s8_wsel, s8_waddr, s8_rp_addr, s8_rq_addr;
    logic [7:0]  s8_cons, s8_din, s8_rp_data;
    logic [2:0]  s8_op;
    logic [3:0]  s8_flags;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [3:0]  sb_q[$];
    logic [15:0] mrf[16];
    logic [3:0]  mflags;

    always #5 clk = ~clk;

    datapath_pipe #(.DW(16), .NREG(16), .CW(8)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .wsel(wsel), .w_addr(w_addr), .w_wr(w_wr), .rp_addr(rp_addr), .rp_rd(rp_rd),
        .rq_addr(rq_addr), .rq_rd(rq_rd), .w_cons(w_cons), .alu_op(alu_op),
        .dm_din(dm_din), .rp_data(rp_data), .rp_zero(rp_zero), .flags(flags),
        .wb_valid(wb_valid)
    );

    datapath_pipe #(.DW(8), .NREG(4), .CW(8)) dut8 (
        .clk(clk), .rst(rst), .issue_valid(s8_valid), .issue_ready(s8_ready),
        .wsel(s8_wsel), .w_addr(s8_waddr), .w_wr(s8_wr), .rp_addr(s8_rp_addr), .rp_rd(s8_rp_rd),
        .rq_addr(s8_rq_addr), .rq_rd(s8_rq_rd), .w_cons(s8_cons), .alu_op(s8_op),
        .dm_din(s8_din), .rp_data(s8_rp_data), .rp_zero(s8_rp_zero), .flags(s8_flags),
        .wb_valid(s8_wbv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each write entering WB pops the flag word the model predicted at issue time.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) chk("sb_flags", flags, sb_q.pop_front());
        end
    end

    task automatic check_reg(input logic [3:0] a, input logic [15:0] exp, input string tag);
        rp_addr = a;
        rp_rd   = 1'b1;
        @(negedge clk);
        chk(tag, rp_data, exp);
        chk({tag, "_z"}, rp_zero, 32'(exp == 16'h0));
    endtask

    task automatic do_op(input logic [1:0] ws, input logic [2:0] op, input logic [3:0] wa,
                         input logic wr, input logic [3:0] pa, input logic [3:0] qa,
                         input logic [7:0] cons, input logic [15:0] din, input string tag);
        logic [15:0] a, b, res;
        logic [31:0] p;
        logic        v, c, mul;
        int          sa, sb, si, n;
        a = mrf[pa];
        b = mrf[qa];
        sa = int'($signed(a));
        sb = int'($signed(b));
        res = a; v = 1'b0; c = 1'b0;
        mul = (ws == 2'd0) && (op == 3'd6);
        case (ws)
            2'd0: case (op)
                3'd0: begin
                    res = a + b; si = sa + sb;
                    c = (int'(a) + int'(b)) > 65535;
                    v = (si > 32767) || (si < -32768);
                end
                3'd1: begin
                    res = a - b; si = sa - sb;
                    c = a < b;
                    v = (si > 32767) || (si < -32768);
                end
                3'd3: res = a & b;
                3'd4: res = a | b;
                3'd5: res = a ^ b;
                3'd6: begin
                    p = {16'h0, a} * {16'h0, b};
                    res = p[15:0];
                    c = (p[31:16] != 16'h0);
                end
                default: res = a;
            endcase
            2'd1: res = din;
            2'd2: res = {8'h00, cons};
            default: begin
                if (a == 16'h8000) begin res = a; v = 1'b1; end
                else res = (sa < 0) ? 16'(-sa) : a;
            end
        endcase
        issue_valid = 1'b1; wsel = ws; alu_op = op; w_addr = wa; w_wr = wr;
        rp_addr = pa; rq_addr = qa; rp_rd = 1'b1; rq_rd = 1'b1; w_cons = cons; dm_din = din;
        if (wr) begin
            mrf[wa] = res;
            if (ws == 2'd0 || ws == 2'd3) mflags = {v, c, res[15], 1'(res == 16'h0)};
            sb_q.push_back(mflags);
        end
        @(posedge clk); #1;
        if (mul) begin
            n = 0;
            // junk on the inputs while stalled must be ignored
            while (!issue_ready && n < 40) begin
                issue_valid = 1'b1; wsel = 'x; alu_op = 'x; w_addr = 'x; w_wr = 'x; dm_din = 'x;
                n++;
                @(posedge clk); #1;
            end
            chk({tag, "_stall"}, n, 16);
        end
        issue_valid = 1'b0; w_wr = 1'b0; wsel = 2'd0; alu_op = 3'd0; w_addr = 4'd0; dm_din = 16'h0;
    endtask

    task automatic s8_issue(input logic [1:0] ws, input logic [2:0] op, input logic [1:0] wa,
                            input logic [1:0] pa, input logic [1:0] qa, input logic [7:0] cons);
        s8_valid = 1'b1; s8_wsel = ws; s8_op = op; s8_waddr = wa; s8_wr = 1'b1;
        s8_rp_addr = pa; s8_rq_addr = qa; s8_cons = cons;
        @(posedge clk); #1;
        s8_valid = 1'b0; s8_wr = 1'b0;
    endtask

    initial begin
        logic [3:0] wrap_addr;
        rst = 1'b1;
        issue_valid = 0; wsel = 0; w_addr = 0; w_wr = 0; rp_addr = 0; rp_rd = 0;
        rq_addr = 0; rq_rd = 0; w_cons = 0; alu_op = 0; dm_din = 0;
        s8_valid = 0; s8_wsel = 0; s8_waddr = 0; s8_wr = 0; s8_rp_addr = 0; s8_rp_rd = 1;
        s8_rq_addr = 0; s8_rq_rd = 1; s8_cons = 0; s8_op = 0; s8_din = 0;
        for (int i = 0; i < 16; i++) mrf[i] = 16'h0;
        mflags = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready", issue_ready, 1);
        chk("rst_flags", flags, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("w8_rst_flags", s8_flags, 0);
        for (int i = 0; i < 16; i++) check_reg(4'(i), 16'h0, "rst_reg");

        // reset in the middle of a multiply: aborted, nothing written
        do_op(2'd2, 3'd0, 4'd7, 1'b1, 4'd0, 4'd0, 8'h03, 16'h0, "c7");
        issue_valid = 1'b1; wsel = 2'd0; alu_op = 3'd6; w_addr = 4'd6; w_wr = 1'b1;
        rp_addr = 4'd7; rq_addr = 4'd7;
        @(posedge clk); #1;
        issue_valid = 1'b0; w_wr = 1'b0; alu_op = 3'd0;
        chk("mul_busy", issue_ready, 0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", issue_ready, 1);
        chk("abort_wbv", wb_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mrf[i] = 16'h0;
        mflags = 4'h0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_flags", flags, 0);
        check_reg(4'd6, 16'h0, "abort_r6");
        check_reg(4'd7, 16'h0, "abort_r7");

        // constant then forwarded ADD
        do_op(2'd2, 3'd0, 4'd1, 1'b1, 4'd0, 4'd0, 8'h05, 16'h0, "c1");
        do_op(2'd0, 3'd0, 4'd2, 1'b1, 4'd1, 4'd1, 8'h00, 16'h0, "add");
        chk("add_flags", flags, 4'b0000);
        check_reg(4'd2, 16'h000A, "r2");

        do_op(2'd2, 3'd0, 4'd3, 1'b1, 4'd0, 4'd0, 8'h03, 16'h0, "c3");
        do_op(2'd2, 3'd0, 4'd4, 1'b1, 4'd0, 4'd0, 8'h05, 16'h0, "c4");
        do_op(2'd0, 3'd1, 4'd5, 1'b1, 4'd3, 4'd4, 8'h00, 16'h0, "sub");
        chk("sub_flags", flags, 4'b0110);
        check_reg(4'd5, 16'hFFFE, "r5_sub");
        do_op(2'd0, 3'd1, 4'd5, 1'b1, 4'd3, 4'd3, 8'h00, 16'h0, "subz");
        chk("subz_flags", flags, 4'b0001);
        check_reg(4'd5, 16'h0000, "r5_subz");

        do_op(2'd1, 3'd0, 4'd9, 1'b1, 4'd0, 4'd0, 8'h00, 16'h8000, "d9a");
        do_op(2'd3, 3'd0, 4'd10, 1'b1, 4'd9, 4'd0, 8'h00, 16'h0, "abs_min");
        chk("abs_min_flags", flags, 4'b1010);
        check_reg(4'd10, 16'h8000, "r10");
        do_op(2'd1, 3'd0, 4'd9, 1'b1, 4'd0, 4'd0, 8'h00, 16'hFFF6, "d9b");
        do_op(2'd3, 3'd0, 4'd11, 1'b1, 4'd9, 4'd0, 8'h00, 16'h0, "abs_neg");
        chk("abs_neg_flags", flags, 4'b0000);
        check_reg(4'd11, 16'h000A, "r11");

        // multiply, then an op issued in the DONE cycle using the product
        do_op(2'd1, 3'd0, 4'd8, 1'b1, 4'd0, 4'd0, 8'h00, 16'h0123, "d8");
        do_op(2'd1, 3'd0, 4'd12, 1'b1, 4'd0, 4'd0, 8'h00, 16'h0100, "d12");
        do_op(2'd0, 3'd6, 4'd13, 1'b1, 4'd8, 4'd12, 8'h00, 16'h0, "mul");
        chk("mul_flags", flags, 4'b0100);
        chk("mul_wbv", wb_valid, 1);
        do_op(2'd0, 3'd2, 4'd14, 1'b1, 4'd13, 4'd0, 8'h00, 16'h0, "fwd");
        chk("fwd_accept", wb_valid, 1);
        check_reg(4'd14, 16'h2300, "r14");
        check_reg(4'd13, 16'h2300, "r13");

        do_op(2'd2, 3'd0, 4'd15, 1'b1, 4'd0, 4'd0, 8'h01, 16'h0, "c15a");
        do_op(2'd2, 3'd0, 4'd15, 1'b1, 4'd0, 4'd0, 8'h02, 16'h0, "c15b");
        check_reg(4'd15, 16'h0002, "r15");

        do_op(2'd0, 3'd5, 4'd6, 1'b1, 4'd1, 4'd2, 8'h00, 16'h0, "xor");
        check_reg(4'd6, 16'h000F, "r6_xor");
        do_op(2'd0, 3'd3, 4'd6, 1'b1, 4'd1, 4'd2, 8'h00, 16'h0, "and");
        chk("and_flags", flags, 4'b0001);
        do_op(2'd0, 3'd4, 4'd6, 1'b1, 4'd1, 4'd2, 8'h00, 16'h0, "or");
        chk("or_flags", flags, 4'b0000);

        // no-write ops must not touch flags or registers
        do_op(2'd0, 3'd1, 4'd0, 1'b0, 4'd3, 4'd3, 8'h00, 16'h0, "sub_nw");
        chk("nw_flags", flags, mflags);
        do_op(2'd0, 3'd6, 4'd7, 1'b0, 4'd8, 4'd12, 8'h00, 16'h0, "mul_nw");
        chk("mulnw_flags", flags, mflags);
        check_reg(4'd7, 16'h0000, "r7_mulnw");

        rp_rd = 1'b0; rp_addr = 4'd2;
        @(negedge clk);
        chk("rp_off", rp_data, 0);
        chk("rp_off_z", rp_zero, 1);

        // narrow instance: carry out of the top bit, address wrap
        s8_issue(2'd2, 3'd0, 2'd3, 2'd0, 2'd0, 8'hFF);
        s8_issue(2'd2, 3'd0, 2'd2, 2'd0, 2'd0, 8'h01);
        s8_issue(2'd0, 3'd0, 2'd1, 2'd3, 2'd2, 8'h00);
        chk("w8_add_flags", s8_flags, 4'b0101);
        s8_rp_addr = 2'd1;
        @(negedge clk);
        chk("w8_r1", s8_rp_data, 8'h00);
        chk("w8_r1_z", s8_rp_zero, 1);
        wrap_addr = 4'd7;
        s8_rp_addr = wrap_addr[1:0];
        @(negedge clk);
        chk("w8_wrap", s8_rp_data, 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        chk("flags_end", flags, mflags);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
Parametrised successor to the single-cycle register-file/ALU datapath. Adds:
- a two-stage pipeline (execute, then writeback) with read-after-write forwarding;
- an iterative multiply mode with an issue handshake;
- a registered status-flag word.

It sits between the controller FSM and data memory. The controller issues one operation per accepted cycle and stalls on `issue_ready`.

Parameters:
DW, 16, datapath/register width (>=4)
NREG, 16, number of registers (power of 2)
AW, $clog2(NREG), register address width
CW, 8, constant-field width (<=DW), zero-extended

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
issue_valid  in  1  controller presents an operation
issue_ready  out  1  block can accept; low while multiply in progress
wsel  in  2  write source: 00 ALU, 01 dm_din, 10 w_cons, 11 abs(Rp)
w_addr  in  AW  destination register
w_wr  in  1  write enable for this operation
rp_addr  in  AW  read port P address
rp_rd  in  1  read port P enable
rq_addr  in  AW  read port Q address
rq_rd  in  1  read port Q enable
w_cons  in  CW  constant operand
alu_op  in  3  0 ADD, 1 SUB, 2 PASSA, 3 AND, 4 OR, 5 XOR, 6 MUL, 7 reserved (acts as PASSA)
dm_din  in  DW  data-memory read data
rp_data  out  DW  forwarded port-P value (0 when rp_rd=0), combinational
rp_zero  out  1  rp_data==0, combinational
flags  out  4  registered {V,C,N,Z}
wb_valid  out  1  writeback stage holds a write this cycle

Behaviour:
- Reset (async, any time): all registers = 0; flags = 0; wb_valid = 0; FSM = IDLE; issue_ready = 1. A multiply in progress is aborted with no writeback.
- Accept: issue_valid && issue_ready at a rising edge. Operands and dm_din/w_cons are sampled at that edge. Inputs are ignored otherwise.
- Read with forwarding:
  - A read returns the WB-stage data when wb_valid and the WB address equals the read address; otherwise it returns the RF content.
  - A disabled port reads 0.
- EX stage (non-MUL, single cycle):
  - Result = mux(wsel) of ALU out, dm_din, zero-extended w_cons, or abs(Rp).
  - Registered at the accept edge into WB (wb_addr, wb_data, wb_valid = w_wr).
- WB stage: the RF is written at the edge after accept. Result visible in the RF 2 edges after issue, and via forwarding to an op issued on the very next cycle.
- Arithmetic, all modulo 2^DW:
  - ADD: C = carry-out.
  - SUB (A-B): C = borrow (A<B unsigned); V = signed overflow.
  - Logic ops: C = 0, V = 0.
  - abs: two's complement. abs(most-negative) = most-negative, V = 1.
  - MUL: low DW bits of the product. C = (high DW bits != 0); V = 0.
- Flags:
  - Updated only when a result enters WB with w_wr = 1 and wsel in {00, 11}.
  - Z = result==0; N = result MSB.
  - wsel 01/10 writes leave flags unchanged.
- MUL FSM (states IDLE, MUL, DONE):
  - IDLE -> MUL on an accepted alu_op=6 with wsel=00. Operands are latched and issue_ready drops the same edge.
  - MUL: unsigned shift-add, one bit per cycle, counter 0..DW-1.
  - MUL -> DONE after DW cycles.
  - DONE: result enters WB and issue_ready = 1. Next cycle returns to IDLE, and a new issue may be accepted in that DONE cycle.
  - Total: DW+1 cycles from accept to WB.
  - MUL with w_wr=0 still runs and updates flags only if w_wr=1, i.e. it is a pure stall.
- Simultaneous events:
  - Issue reading the address WB is writing gets the WB data (forwarding).
  - Back-to-back writes to the same register: the later one wins.
- issue_valid with X inputs while issue_ready=0: no state change.

Decomposition:
- Package `dp_pkg`: alu_op_t enum, wsel_t enum, flags_t packed struct {v,c,n,z}, mul_state_t enum, op encodings.
- One sub-module, `dp_mul_iter`: iterative shift-add multiplier with start/done and DW/counter internal.
- Register array, forwarding and ALU are inline in `datapath_pipe`.

Test Plan:
- Reset, then read all registers via rp -> each reads 0; flags=0; issue_ready=1. Assert rst mid-MUL -> no write, issue_ready=1 within the same cycle.
- Const write R1=0x05, next cycle ADD R2=R1+R1 (forwarding) -> R2=0x000A, flags Z=0 N=0 C=0 V=0.
- SUB with R3=0x0003, R4=0x0005, R5=R3-R4 -> 0xFFFE, N=1, C=1, V=0. Then SUB R5=R3-R3 -> 0, Z=1.
- abs(0x8000) -> 0x8000 with V=1. abs(0xFFF6) -> 0x000A with V=0.
- MUL 0x0123*0x0100 (DW=16):
  - issue_ready low for exactly 16 cycles;
  - R = 0x2300, C=1;
  - a back-to-back issue in the DONE cycle is accepted and forwards the product.
- Parameter sweep DW=8, NREG=4: ADD 0xFF+0x01 -> 0x00, Z=1, C=1. Addresses wrap within 2 bits.
